// File: rtl/regfile_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_write_sequencer_if
//
// Handshake and register-file write bus of the write-back sequencer.
//
// Signals:
//   in_valid  producer -> sequencer  request present
//   in_ready  sequencer -> producer  request accepted when valid && ready
//   in_dstE   producer -> sequencer  E destination (4'hF = none)
//   in_dstM   producer -> sequencer  M destination (4'hF = none)
//   in_valE   producer -> sequencer  ALU result
//   in_valM   producer -> sequencer  memory read data
//   in_cnd    producer -> sequencer  condition flag, 0 cancels the E write
//   rf_we     sequencer -> regfile   write enable
//   rf_waddr  sequencer -> regfile   write address
//   rf_wdata  sequencer -> regfile   write data
//   done      sequencer -> producer  one-cycle retirement pulse
//   wb_count  sequencer -> observer  retired-request counter (wrapping)
//
// Modports: master = producer / observer side, slave = sequencer.
// ---------------------------------------------------------------------------
interface regfile_write_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_dstE;
   logic [3:0]  in_dstM;
   logic [63:0] in_valE;
   logic [63:0] in_valM;
   logic        in_cnd;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        done;
   logic [15:0] wb_count;

   modport master (
      output in_valid, in_dstE, in_dstM, in_valE, in_valM, in_cnd,
      input  in_ready, rf_we, rf_waddr, rf_wdata, done, wb_count
   );

   modport slave (
      input  in_valid, in_dstE, in_dstM, in_valE, in_valM, in_cnd,
      output in_ready, rf_we, rf_waddr, rf_wdata, done, wb_count
   );
endinterface

// File: rtl/regfile_write_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_write_sequencer
//
// Serialises the (up to) two write-back results of one instruction onto a
// single register-file write port: E result first, then M result, then a
// one-cycle done pulse. Moore FSM, so every output is a function of the state
// register and the request registers latched on acceptance.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  regfile_write_sequencer_if.slave (request handshake, regfile write
//        port, done pulse, wb_count)
// ---------------------------------------------------------------------------
module regfile_write_sequencer (
   input  logic                      clk,
   input  logic                      rst,
   regfile_write_sequencer_if.slave  bus
);

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR_E = 2'd1,
      WR_M = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_reg, state_next;

   logic [3:0]  dst_e_reg, dst_m_reg;
   logic [63:0] val_e_reg, val_m_reg;
   logic        eff_m_reg;

   logic [15:0] wb_count_reg;

   // Request decode, only meaningful in IDLE.
   logic accept;
   logic eff_e_in, eff_m_in, issue_e_in;

   assign accept   = bus.in_valid && (state_reg == IDLE);
   assign eff_e_in = (bus.in_dstE != REG_NONE) && bus.in_cnd;
   assign eff_m_in = (bus.in_dstM != REG_NONE);
   // Same destination on both ports: the M value wins (popq %rsp), so the
   // E write is suppressed entirely rather than being overwritten later.
   assign issue_e_in = eff_e_in && !(eff_m_in && (bus.in_dstE == bus.in_dstM));

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (issue_e_in)      state_next = WR_E;
               else if (eff_m_in)   state_next = WR_M;
               else                 state_next = DONE;
            end
         end
         WR_E:    state_next = eff_m_reg ? WR_M : DONE;
         WR_M:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- request latch ----------------
   // Loaded only on acceptance; held untouched while the request is sequenced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dst_e_reg <= REG_NONE;
         dst_m_reg <= REG_NONE;
         val_e_reg <= 64'h0;
         val_m_reg <= 64'h0;
         eff_m_reg <= 1'b0;
      end else if (accept) begin
         dst_e_reg <= bus.in_dstE;
         dst_m_reg <= bus.in_dstM;
         val_e_reg <= bus.in_valE;
         val_m_reg <= bus.in_valM;
         eff_m_reg <= eff_m_in;
      end
   end

   // ---------------- retirement counter ----------------
   // Free-running wrap at 16 bits; one increment per DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_count_reg <= 16'h0000;
      end else if (state_reg == DONE) begin
         wb_count_reg <= wb_count_reg + 16'h0001;
      end
   end

   // ---------------- Moore outputs ----------------
   logic        rf_we_next;
   logic [3:0]  rf_waddr_next;
   logic [63:0] rf_wdata_next;
   logic        done_next;
   logic        in_ready_next;

   always_comb begin
      rf_we_next    = 1'b0;
      rf_waddr_next = REG_NONE;
      rf_wdata_next = 64'h0;
      done_next     = 1'b0;
      in_ready_next = 1'b0;
      case (state_reg)
         IDLE: in_ready_next = 1'b1;
         WR_E: begin
            rf_we_next    = 1'b1;
            rf_waddr_next = dst_e_reg;
            rf_wdata_next = val_e_reg;
         end
         WR_M: begin
            rf_we_next    = 1'b1;
            rf_waddr_next = dst_m_reg;
            rf_wdata_next = val_m_reg;
         end
         DONE: done_next = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_ready = in_ready_next;
   assign bus.rf_we    = rf_we_next;
   assign bus.rf_waddr = rf_waddr_next;
   assign bus.rf_wdata = rf_wdata_next;
   assign bus.done     = done_next;
   assign bus.wb_count = wb_count_reg;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_sequencer
//
// Directed bench for regfile_write_sequencer. Inputs are driven on the
// falling edge, outputs sampled on the falling edge (half a cycle after the
// active edge). The packed vector obs = {rf_we, rf_waddr, rf_wdata, done,
// in_ready} is compared against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_regfile_write_sequencer;

   logic clk;
   logic rst;

   regfile_write_sequencer_if bus ();

   regfile_write_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;
   logic [15:0] exp_count;

   // {rf_we, rf_waddr, rf_wdata, done, in_ready}
   wire [70:0] obs = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.in_ready};

   localparam logic [70:0] OBS_IDLE = {1'b0, 4'hF, 64'h0, 1'b0, 1'b1};
   localparam logic [70:0] OBS_DONE = {1'b0, 4'hF, 64'h0, 1'b1, 1'b0};

   // Presents one request on a falling edge, lets it be taken on the next
   // rising edge (T), and withdraws it on the following falling edge, which
   // is where cycle T+1 is observed.
   task automatic drive_req(input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] ve, input logic [63:0] vm,
                            input logic c);
      bus.in_dstE  = de;
      bus.in_dstM  = dm;
      bus.in_valE  = ve;
      bus.in_valM  = vm;
      bus.in_cnd   = c;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.wb_count} !==
          {1'b0, 4'hF, 64'h0, 1'b0, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b addr=%h data=%h done=%b cnt=%h, want 0 f 0 0 0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.wb_count);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_IDLE) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %h, want %h", obs, OBS_IDLE);
      end
      exp_count = 16'h0;
      $display("reset: released, in_ready=%b wb_count=%h", bus.in_ready, bus.wb_count);
   endtask

   task automatic test_mrmovq();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mrmovq_ready: got %b, want 1", bus.in_ready);
      end
      drive_req(4'hF, 4'h3, 64'hDEAD, 64'h1122, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 4'h3, 64'h1122, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL mrmovq_T1_write: got %h, want r3=1122", obs);
      end
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_DONE) begin
         n_fail++;
         $display("FAIL mrmovq_T2_done: got %h, want %h", obs, OBS_DONE);
      end
      exp_count++;
      @(negedge clk);
      n_checks++;
      if ({obs, bus.wb_count} !== {OBS_IDLE, 16'h0001}) begin
         n_fail++;
         $display("FAIL mrmovq_count: got obs=%h cnt=%h, want idle cnt=0001", obs, bus.wb_count);
      end
      $display("mrmovq: r3<=1122, wb_count=%h", bus.wb_count);
   endtask

   task automatic test_popq_rbx();
      drive_req(4'h4, 4'h3, 64'h108, 64'hAB, 1'b1);
      // Inputs changed while busy must not disturb the latched request.
      bus.in_dstE = 4'h9;
      bus.in_dstM = 4'hA;
      bus.in_valE = 64'hBAD0;
      bus.in_valM = 64'hBAD1;
      n_checks++;
      if (obs !== {1'b1, 4'h4, 64'h108, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL popq_rbx_T1_E: got %h, want r4=108", obs);
      end
      @(negedge clk);
      n_checks++;
      if (obs !== {1'b1, 4'h3, 64'hAB, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL popq_rbx_T2_M: got %h, want r3=ab", obs);
      end
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_DONE) begin
         n_fail++;
         $display("FAIL popq_rbx_T3_done: got %h, want %h", obs, OBS_DONE);
      end
      exp_count++;
      @(negedge clk);
      n_checks++;
      if ({obs, bus.wb_count} !== {OBS_IDLE, exp_count}) begin
         n_fail++;
         $display("FAIL popq_rbx_count: got obs=%h cnt=%h, want idle cnt=%h", obs, bus.wb_count, exp_count);
      end
      $display("popq_rbx: r4<=108 then r3<=ab, wb_count=%h", bus.wb_count);
   endtask

   task automatic test_popq_rsp();
      drive_req(4'h4, 4'h4, 64'h108, 64'h55, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 4'h4, 64'h55, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL popq_rsp_T1_M_only: got %h, want r4=55", obs);
      end
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_DONE) begin
         n_fail++;
         $display("FAIL popq_rsp_T2_done: got %h, want %h", obs, OBS_DONE);
      end
      exp_count++;
      @(negedge clk);
      n_checks++;
      if ({obs, bus.wb_count} !== {OBS_IDLE, exp_count}) begin
         n_fail++;
         $display("FAIL popq_rsp_count: got obs=%h cnt=%h, want idle cnt=%h", obs, bus.wb_count, exp_count);
      end
      $display("popq_rsp: r4<=55 single write, wb_count=%h", bus.wb_count);
   endtask

   task automatic test_cmov();
      drive_req(4'h2, 4'hF, 64'h77, 64'h0, 1'b0);
      n_checks++;
      if (obs !== OBS_DONE) begin
         n_fail++;
         $display("FAIL cmov_not_taken_T1_done: got %h, want %h", obs, OBS_DONE);
      end
      exp_count++;
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_IDLE) begin
         n_fail++;
         $display("FAIL cmov_not_taken_idle: got %h, want %h", obs, OBS_IDLE);
      end
      $display("cmov_not_taken: no write, wb_count=%h", bus.wb_count);
      drive_req(4'h2, 4'hF, 64'h77, 64'h0, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 4'h2, 64'h77, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL cmov_taken_T1_write: got %h, want r2=77", obs);
      end
      @(negedge clk);
      n_checks++;
      if (obs !== OBS_DONE) begin
         n_fail++;
         $display("FAIL cmov_taken_T2_done: got %h, want %h", obs, OBS_DONE);
      end
      exp_count++;
      @(negedge clk);
      n_checks++;
      if ({obs, bus.wb_count} !== {OBS_IDLE, exp_count}) begin
         n_fail++;
         $display("FAIL cmov_count: got obs=%h cnt=%h, want idle cnt=%h", obs, bus.wb_count, exp_count);
      end
      $display("cmov_taken: r2<=77, wb_count=%h", bus.wb_count);
   endtask

   task automatic test_reset_midop();
      drive_req(4'h4, 4'h3, 64'h108, 64'hAB, 1'b1);
      n_checks++;
      if (obs !== {1'b1, 4'h4, 64'h108, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midop_WR_E: got %h, want r4=108", obs);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.wb_count} !==
          {1'b0, 4'hF, 64'h0, 1'b0, 16'h0}) begin
         n_fail++;
         $display("FAIL midop_async_reset: got we=%b addr=%h data=%h done=%b cnt=%h, want 0 f 0 0 0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done, bus.wb_count);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_count = 16'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({obs, bus.wb_count} !== {OBS_IDLE, 16'h0}) begin
            n_fail++;
            $display("FAIL midop_after_release[%0d]: got obs=%h cnt=%h, want idle cnt=0000", i, obs, bus.wb_count);
         end
      end
      $display("reset_midop: request abandoned, wb_count=%h", bus.wb_count);
   endtask

   task automatic test_back_to_back();
      int acc;
      int dones;
      int cyc;
      // Preload the counter close to wrap; walking 65k requests would cost
      // more simulated time than the rest of the bench combined.
      force dut.wb_count_reg = 16'hFF80;
      @(posedge clk);
      @(negedge clk);
      release dut.wb_count_reg;
      @(negedge clk);
      exp_count = 16'hFF80;
      n_checks++;
      if (bus.wb_count !== exp_count) begin
         n_fail++;
         $display("FAIL b2b_preload: got %h, want %h", bus.wb_count, exp_count);
      end
      acc = 0;
      dones = 0;
      cyc = 0;
      bus.in_dstE  = 4'hF;
      bus.in_dstM  = 4'hF;
      bus.in_cnd   = 1'b1;
      bus.in_valid = 1'b1;
      while ((acc < 300 || bus.in_valid) && cyc < 2000) begin
         if (bus.done) begin
            n_checks++;
            if (bus.wb_count !== exp_count) begin
               n_fail++;
               $display("FAIL b2b_count[%0d]: got %h, want %h", dones, bus.wb_count, exp_count);
            end
            exp_count++;
            dones++;
         end
         if (bus.in_ready && bus.in_valid) acc++;
         @(posedge clk);
         #1;
         if (acc == 300) bus.in_valid = 1'b0;
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc >= 2000) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d cycles, want under 2000", cyc);
      end
      // Drain the last request's done pulse.
      for (int i = 0; i < 3; i++) begin
         if (bus.done) begin
            exp_count++;
            dones++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 300) begin
         n_fail++;
         $display("FAIL b2b_done_pulses: got %0d, want 300", dones);
      end
      n_checks++;
      if ({obs, bus.wb_count} !== {OBS_IDLE, 16'h00AC}) begin
         n_fail++;
         $display("FAIL b2b_final_count: got obs=%h cnt=%h, want idle cnt=00ac", obs, bus.wb_count);
      end
      $display("back_to_back: %0d requests in %0d cycles, wb_count=%h", dones, cyc, bus.wb_count);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      exp_count    = 16'h0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_dstE  = 4'hF;
      bus.in_dstM  = 4'hF;
      bus.in_valE  = 64'h0;
      bus.in_valM  = 64'h0;
      bus.in_cnd   = 1'b1;
      @(negedge clk);
      test_reset();
      test_mrmovq();
      test_popq_rbx();
      test_popq_rsp();
      test_cmov();
      test_reset_midop();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
